alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the 8-bit combinational ALU: same 16-op map, WIDTH-generic operands.
//  Adds registered results, zero/div-by-zero flags, and iterative multi-cycle multiply/divide.
//  Sits between the operand-issue stage and writeback; valid/ready on both sides.
// PARAMETERS
//  WIDTH   8   operand/result width, >=4; sets mul/div iteration count
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  in_valid     in   1      operands/opcode valid
//  in_ready     out  1      block accepts op this cycle
//  a, b         in   WIDTH  operands, unsigned
//  alu_sel      in   4      opcode, same encoding as 8-bit ALU (0000 add .. 1111 eq)
//  out_valid    out  1      result valid, held until out_ready
//  out_ready    in   1      consumer takes result
//  alu_out      out  WIDTH  result
//  carryout     out  1      carry/borrow/shifted-out bit
//  zero         out  1      alu_out == 0
//  div_by_zero  out  1      divide op with b == 0
//  busy         out  1      iterative op in progress
// BEHAVIOUR
//  - Reset: state IDLE; alu_out, carryout, zero, div_by_zero, out_valid, busy all 0; iteration counter 0.
//  - FSM IDLE -> (accept, mul/div with b!=0) BUSY -> DONE; IDLE -> (accept, other op) DONE.
//    DONE -> IDLE on out_ready & !in_valid; DONE -> DONE/BUSY on out_ready & in_valid (new accept).
//  - in_ready = (IDLE) | (DONE & out_ready); accept = in_valid & in_ready. Operands captured at accept;
//    later changes on a/b/alu_sel have no effect.
//  - Latency: single-cycle ops 1 clk (out_valid after the accept edge); mul/div exactly WIDTH clks.
//    Back-to-back single-cycle ops sustain 1 op/clk while out_ready=1.
//  - Outputs registered, stable while out_valid & !out_ready. busy = (state == BUSY).
//  - Arithmetic (unsigned, WIDTH bits): add carry = bit WIDTH of sum; sub carry = borrow (a<b);
//    mul: alu_out = low WIDTH of a*b, carry = |high WIDTH bits; div: alu_out = a/b, carry 0.
//  - Shifts/rotates: shl carry = a[MSB]; shr carry = a[0]; rol/ror carry = bit rotated across.
//  - Logic ops and compares: carry 0; gt/eq return 1 or 0 zero-extended to WIDTH.
//  - Divide by zero: no BUSY; single-cycle completion, alu_out all-ones, carry 0, div_by_zero 1.
//    div_by_zero 0 for every other completion.
//  - zero recomputed on every completion, from final alu_out.
//  - Multiply: shift-add, one partial product per clk. Divide: restoring, one quotient bit per clk.
//  - Reset mid-BUSY aborts the op; no result is presented.
// CONFIGURATION
//  ALU_DIV_EN defined: divide op 0011 as above (iterative, div-by-zero handling).
//  ALU_DIV_EN undefined: divider datapath absent; op 0011 completes in 1 clk with
//   alu_out 0, carry 0, div_by_zero 0. Multiply remains iterative.
// STRUCTURE
//  alu_pkg: opcode localparams (OP_ADD..OP_EQ), FSM state enum (S_IDLE, S_BUSY, S_DONE).
//  Sub-module alu_muldiv_iter: WIDTH-param iterative multiplier/divider; start, op, a, b in;
//   done, result, hi_nonzero out. Divider section wrapped in `ifdef ALU_DIV_EN.
//  Top: handshake FSM, single-cycle combinational ops, output registers.
// TESTING (WIDTH=8 unless noted)
//  add a=0xFF b=0x01, out_ready=1 -> 1 clk later out_valid, alu_out 0x00, carry 1, zero 1
//  mul a=0x10 b=0x20 -> busy 8 clks, alu_out 0x00, carry 1, zero 1; in_ready 0 while busy
//  div a=100 b=7 -> alu_out 14 after 8 clks; div a=5 b=0 -> 1 clk, alu_out 0xFF, div_by_zero 1
//  out_ready=0 on and after completion of xor 0xAA^0x0F -> alu_out 0xA5 held, in_ready 0, next op not accepted
//  20 back-to-back rol ops, out_ready=1 -> one result per clk, rol 0x81 = 0x03 carry 1
//  rst asserted mid-mul -> out_valid/busy 0 immediately; next add 3+4 gives 7, carry 0

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and build options for the sequential ALU.
// Build option: ALU_DIV_EN enables the iterative divider.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider, one step per clock.
// Build option: ALU_DIV_EN adds the divider datapath.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             hi_nonzero
);

    localparam int CW = $clog2(WIDTH);

    // acc: product high half / remainder; q: multiplier / quotient
    logic             active;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   msum;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] q_n;
`ifdef ALU_DIV_EN
    logic             op_q;
    logic [WIDTH:0]   rsh;
    logic [WIDTH:0]   rdiff;
`endif

    // One iteration step; the final step's value is handed out directly
    always_comb begin
        msum       = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        acc_n      = msum[WIDTH:1];
        q_n        = {msum[0], q[WIDTH-1:1]};
        hi_nonzero = |acc_n;
`ifdef ALU_DIV_EN
        rsh   = {acc, q[WIDTH-1]};
        rdiff = rsh - {1'b0, m};
        if (op_q) begin
            acc_n      = rdiff[WIDTH] ? rsh[WIDTH-1:0] : rdiff[WIDTH-1:0];
            q_n        = {q[WIDTH-2:0], ~rdiff[WIDTH]};
            hi_nonzero = 1'b0;
        end
`endif
        result = q_n;
        done   = active && (cnt == CW'(WIDTH - 1));
    end

    // Operand load on start, then WIDTH steps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
`ifdef ALU_DIV_EN
            op_q   <= 1'b0;
`endif
        end else if (start && (DIV_EN || !op)) begin
            active <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            q      <= op ? a : b;
            m      <= op ? b : a;
`ifdef ALU_DIV_EN
            op_q   <= op;
`endif
        end else if (active) begin
            acc <= acc_n;
            q   <= q_n;
            if (done) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: 16-op map, registered results, iterative mul/div.
// Build option: ALU_DIV_EN enables divide (op 0011); otherwise it returns 0.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             carryout,
    output logic             zero,
    output logic             div_by_zero,
    output logic             busy
);

    state_t           state;
    state_t           state_n;
    logic             accept;
    logic             is_iter;
    logic             md_done;
    logic             md_hi;
    logic [WIDTH-1:0] md_res;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_dbz;

    assign is_iter = (alu_sel == OP_MUL)
                   | (DIV_EN && (alu_sel == OP_DIV) && (b != '0));

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk        (clk),
        .rst        (rst),
        .start      (accept && is_iter),
        .op         (alu_sel == OP_DIV),
        .a          (a),
        .b          (b),
        .done       (md_done),
        .result     (md_res),
        .hi_nonzero (md_hi)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state: accept launches either an iteration or a direct result
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (accept) state_n = is_iter ? S_BUSY : S_DONE;
            S_BUSY: if (md_done) state_n = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    if (accept) state_n = is_iter ? S_BUSY : S_DONE;
                    else        state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Handshake and status outputs
    always_comb begin
        in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
        out_valid = (state == S_DONE);
        busy      = (state == S_BUSY);
        accept    = in_valid && in_ready;
    end

    // Single-cycle operations (mul and nonzero div go through u_md)
    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_dbz = 1'b0;
        unique case (alu_sel)
            OP_ADD:  {sc_c, sc_res} = {1'b0, a} + {1'b0, b};
            OP_SUB:  begin
                sc_res = a - b;
                sc_c   = (a < b);
            end
`ifdef ALU_DIV_EN
            OP_DIV:  begin
                sc_res = '1;
                sc_dbz = 1'b1;
            end
`endif
            OP_SHL:  begin
                sc_res = {a[WIDTH-2:0], 1'b0};
                sc_c   = a[WIDTH-1];
            end
            OP_SHR:  begin
                sc_res = {1'b0, a[WIDTH-1:1]};
                sc_c   = a[0];
            end
            OP_ROL:  begin
                sc_res = {a[WIDTH-2:0], a[WIDTH-1]};
                sc_c   = a[WIDTH-1];
            end
            OP_ROR:  begin
                sc_res = {a[0], a[WIDTH-1:1]};
                sc_c   = a[0];
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOR:  sc_res = ~(a | b);
            OP_NAND: sc_res = ~(a & b);
            OP_XNOR: sc_res = ~(a ^ b);
            OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (a == b)};
            default: sc_res = '0;
        endcase
    end

    // Result registers, loaded on a direct accept or on the last iteration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out     <= '0;
            carryout    <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept && !is_iter) begin
            alu_out     <= sc_res;
            carryout    <= sc_c;
            zero        <= (sc_res == '0);
            div_by_zero <= sc_dbz;
        end else if ((state == S_BUSY) && md_done) begin
            alu_out     <= md_res;
            carryout    <= md_hi;
            zero        <= (md_res == '0);
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: transaction-level reference model,
// directed scenarios and randomized traffic with random backpressure.
module tb_alu_seq;

    localparam int W = 8;

    localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  MUL = 4'd2,  DIV = 4'd3;
    localparam logic [3:0] SHL = 4'd4,  SHR = 4'd5,  ROL = 4'd6,  ROR = 4'd7;
    localparam logic [3:0] XOR = 4'd10, GT  = 4'd14;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   alu_sel = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] alu_out;
    logic         carryout;
    logic         zero;
    logic         div_by_zero;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .alu_sel     (alu_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_out     (alu_out),
        .carryout    (carryout),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference result of one operation, straight from the op definitions
    function automatic void ref_op(input logic [3:0] s,
                                   input logic [W-1:0] x, y,
                                   output logic [W-1:0] r,
                                   output logic c, output logic d,
                                   output int nbusy);
        logic [2*W-1:0] full;
        r = '0; c = 1'b0; d = 1'b0; nbusy = 0; full = '0;
        case (s)
            ADD: begin full = x + y; r = full[W-1:0]; c = full[W]; end
            SUB: begin r = x - y; c = (x < y); end
            MUL: begin
                full = x * y; r = full[W-1:0];
                c = (full >> W) != 0; nbusy = W;
            end
            DIV: begin
`ifdef ALU_DIV_EN
                if (y == 0) begin r = '1; d = 1'b1; end
                else begin r = x / y; nbusy = W; end
`else
                r = '0;
`endif
            end
            SHL: begin full = x << 1; r = full[W-1:0]; c = full[W]; end
            SHR: begin r = x >> 1; c = (x % 2) != 0; end
            ROL: begin r = (x << 1) | (x >> (W-1)); c = (x >> (W-1)) != 0; end
            ROR: begin r = (x >> 1) | (x << (W-1)); c = (x % 2) != 0; end
            4'd8:  r = x & y;
            4'd9:  r = x | y;
            XOR:   r = x ^ y;
            4'd11: r = ~(x | y);
            4'd12: r = ~(x & y);
            4'd13: r = ~(x ^ y);
            GT:    r = W'(x > y);
            default: r = W'(x == y);
        endcase
    endfunction

    // Transaction model: a pending iterative result counts down, then presents
    logic         m_valid = 1'b0;
    logic         m_pend = 1'b0;
    int           m_rem = 0;
    logic [W-1:0] e_out = '0, p_out = '0;
    logic         e_c = 1'b0, e_d = 1'b0, p_c = 1'b0, p_d = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic         acc;
        logic [W-1:0] r;
        logic         c, d;
        int           nb;
        if (rst) begin
            m_valid = 1'b0;
            m_pend  = 1'b0;
            m_rem   = 0;
        end else begin
            acc = in_valid && !m_pend && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_pend) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_pend = 1'b0; m_valid = 1'b1;
                    e_out = p_out; e_c = p_c; e_d = p_d;
                end
            end
            if (acc) begin
                ref_op(alu_sel, a, b, r, c, d, nb);
                if (nb == 0) begin
                    m_valid = 1'b1; e_out = r; e_c = c; e_d = d;
                end else begin
                    m_pend = 1'b1; m_rem = nb;
                    p_out = r; p_c = c; p_d = d;
                end
            end
        end
    end

    // Compare process, away from the active edge
    always @(negedge clk) begin
        chk("out_valid", out_valid, m_valid);
        chk("busy", busy, m_pend);
        chk("in_ready", in_ready, !m_pend && (!m_valid || out_ready));
        if (m_valid) begin
            chk("alu_out", alu_out, e_out);
            chk("carryout", carryout, e_c);
            chk("zero", zero, e_out == '0);
            chk("div_by_zero", div_by_zero, e_d);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (n) cyc();
    endtask

    // Issue one op with out_ready=1; returns when its result is presented
    task automatic issue(input logic [W-1:0] x, y, input logic [3:0] s,
                         input int nbusy);
        a = x; b = y; alu_sel = s;
        in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        a = ~x; b = ~y;
        for (int i = 0; i < nbusy; i++) begin
            chk("busy_during_iter", busy, 1'b1);
            chk("in_ready_during_iter", in_ready, 1'b0);
            cyc();
        end
        chk("result_valid", out_valid, 1'b1);
    endtask

    initial begin
        logic [W-1:0] r;
        logic         c, d;
        int           nb;

        ref_op(ADD, 8'hFF, 8'h01, r, c, d, nb);
        chk("model_add", {c, r}, 9'h100);
        ref_op(ROL, 8'h81, 8'h00, r, c, d, nb);
        chk("model_rol", {c, r}, 9'h103);
        ref_op(MUL, 8'h10, 8'h20, r, c, d, nb);
        chk("model_mul", {c, r}, 9'h100);
        ref_op(SUB, 8'h03, 8'h05, r, c, d, nb);
        chk("model_sub", {c, r}, 9'h1FE);
        ref_op(ROR, 8'h01, 8'h00, r, c, d, nb);
        chk("model_ror", {c, r}, 9'h180);
        ref_op(GT, 8'h05, 8'h03, r, c, d, nb);
        chk("model_gt", r, 8'h01);

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_out", alu_out, 0);
        chk("rst_flags", {carryout, zero, div_by_zero}, 3'b000);
        rst = 1'b0;
        idle(2);

        issue(8'hFF, 8'h01, ADD, 0);
        chk("add_out", alu_out, 8'h00);
        chk("add_cz", {carryout, zero}, 2'b11);
        idle(2);

        issue(8'h10, 8'h20, MUL, W);
        chk("mul_out", alu_out, 8'h00);
        chk("mul_cz", {carryout, zero}, 2'b11);
        idle(2);

`ifdef ALU_DIV_EN
        issue(8'd100, 8'd7, DIV, W);
        chk("div_out", alu_out, 8'd14);
        chk("div_dbz", div_by_zero, 1'b0);
        idle(2);
        issue(8'd5, 8'd0, DIV, 0);
        chk("div0_out", alu_out, 8'hFF);
        chk("div0_dbz", div_by_zero, 1'b1);
        chk("div0_c", carryout, 1'b0);
`else
        issue(8'd100, 8'd7, DIV, 0);
        chk("div_off_out", alu_out, 8'h00);
        chk("div_off_dbz", {carryout, div_by_zero}, 2'b00);
`endif
        idle(2);

        a = 8'hAA; b = 8'h0F; alu_sel = XOR;
        in_valid = 1'b1; out_ready = 1'b0;
        cyc();
        a = 8'h01; b = 8'h01; alu_sel = ADD;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_out", alu_out, 8'hA5);
            chk("hold_in_ready", in_ready, 1'b0);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        chk("after_hold_out", alu_out, 8'h02);
        idle(2);

        in_valid = 1'b1; out_ready = 1'b1; alu_sel = ROL;
        for (int i = 0; i < 20; i++) begin
            a = (i == 0) ? 8'h81 : W'($urandom);
            ref_op(ROL, a, b, r, c, d, nb);
            cyc();
            chk("rol_valid", out_valid, 1'b1);
            chk("rol_out", {carryout, alu_out}, {c, r});
            if (i == 0) chk("rol_81", {carryout, alu_out}, 9'h103);
        end
        idle(2);

        a = 8'h37; b = 8'h5B; alu_sel = MUL;
        in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        a = 8'd3; b = 8'd4; alu_sel = ADD; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_add", {carryout, alu_out}, 9'h007);
        idle(2);

        for (int n = 0; n < 1500; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            alu_sel   = 4'($urandom_range(0, 15));
            a         = W'($urandom);
            b         = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            cyc();
        end
        idle(2 * W + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
